pc_update_ctrl: RTL

//  Sequencer for the PC source mux and PC register write enable in the multicycle CPU.
//  - Arbitrates per-instruction PC update requests from the main control unit.
//  - Runs the multi-cycle exception entry: EPC save, vector byte read, PC load from Mem.
//  - Drives pc_mux_sel with the existing PCmux encoding:
//    000 A, 001 ULAout, 010 SLAC, 011 EPCout, 100 MDRout, 101 ULAresult, 110 Mem.

---
 rtl/pc_ctrl_pkg.sv | 29 ++
 rtl/pc_req_arbiter.sv | 58 +++++
 rtl/pc_update_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC update path: PCmux select codes, exception
// cause codes and the exception-entry sequencer state encoding. Used by the
// PCmux datapath, the main control unit and pc_update_ctrl.
package pc_ctrl_pkg;

    // PCmux select codes
    localparam logic [2:0] PCSEL_A         = 3'b000;
    localparam logic [2:0] PCSEL_ULAOUT    = 3'b001;
    localparam logic [2:0] PCSEL_SLAC      = 3'b010;
    localparam logic [2:0] PCSEL_EPCOUT    = 3'b011;
    localparam logic [2:0] PCSEL_MDROUT    = 3'b100;
    localparam logic [2:0] PCSEL_ULARESULT = 3'b101;
    localparam logic [2:0] PCSEL_MEM       = 3'b110;

    // Exception cause codes
    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_OPCODE = 2'b01;
    localparam logic [1:0] CAUSE_OVF    = 2'b10;
    localparam logic [1:0] CAUSE_DIV0   = 2'b11;

    // Exception-entry sequencer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_EXC_SAVE = 2'b01,
        ST_EXC_RD   = 2'b10,
        ST_EXC_LOAD = 2'b11
    } pc_state_e;

endpackage

// File: rtl/pc_req_arbiter.sv
// Fixed-priority encoder for per-instruction PC update requests.
// Priority: exc_opcode > exc_ovf > exc_div0 > rte > jr > j > taken branch > step.
// An untaken branch is not a request on its own; step_req may still win.
module pc_req_arbiter
    import pc_ctrl_pkg::*;
(
    input  logic       step_req,
    input  logic       br_req,
    input  logic       br_taken,
    input  logic       j_req,
    input  logic       jr_req,
    input  logic       rte_req,
    input  logic       exc_opcode,
    input  logic       exc_ovf,
    input  logic       exc_div0,
    output logic [2:0] sel,
    output logic       write,
    output logic       is_exc,
    output logic [1:0] cause
);

    // Pick the single highest-priority request of this cycle
    always_comb begin
        sel    = PCSEL_ULARESULT;
        write  = 1'b0;
        is_exc = 1'b0;
        cause  = CAUSE_NONE;
        if (exc_opcode) begin
            is_exc = 1'b1;
            cause  = CAUSE_OPCODE;
        end else if (exc_ovf) begin
            is_exc = 1'b1;
            cause  = CAUSE_OVF;
        end else if (exc_div0) begin
            is_exc = 1'b1;
            cause  = CAUSE_DIV0;
        end else if (rte_req) begin
            sel   = PCSEL_EPCOUT;
            write = 1'b1;
        end else if (jr_req) begin
            sel   = PCSEL_A;
            write = 1'b1;
        end else if (j_req) begin
            sel   = PCSEL_SLAC;
            write = 1'b1;
        end else if (br_req && br_taken) begin
            sel   = PCSEL_ULAOUT;
            write = 1'b1;
        end else if (step_req) begin
            sel   = PCSEL_ULARESULT;
            write = 1'b1;
        end else begin
            sel   = PCSEL_ULARESULT;
            write = 1'b0;
        end
    end

endmodule

// File: rtl/pc_update_ctrl.sv
// PC source mux / PC write sequencer for the multicycle CPU.
// Ordinary PC updates are granted combinationally in the request cycle; an
// exception runs EPC save -> vector read (MEM_LAT cycles) -> PC load from Mem.
// Optional feature macro: EXC_CAUSE_STICKY_EN (exc_cause becomes a sticky
// status register cleared by a serviced rte_req).
module pc_update_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int         MEM_LAT    = 2,
    parameter logic [7:0] VEC_OPCODE = 8'd253,
    parameter logic [7:0] VEC_OVF    = 8'd254,
    parameter logic [7:0] VEC_DIV0   = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_req,
    input  logic       br_req,
    input  logic       br_taken,
    input  logic       j_req,
    input  logic       jr_req,
    input  logic       rte_req,
    input  logic       exc_opcode,
    input  logic       exc_ovf,
    input  logic       exc_div0,
    output logic [2:0] pc_mux_sel,
    output logic       pc_write,
    output logic       epc_write,
    output logic       mem_rd,
    output logic [7:0] vec_addr,
    output logic       busy,
    output logic [1:0] exc_cause
);

    localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    pc_state_e        state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       last_sel_r;
    logic [1:0]       cause_r;
    logic [7:0]       vec_r;
    logic [7:0]       vec_sel_s;
    logic [2:0]       sel_s;
    logic             pc_write_s;
    logic [2:0]       arb_sel_s;
    logic             arb_write_s;
    logic             arb_is_exc_s;
    logic [1:0]       arb_cause_s;
    logic             take_exc_s;
    logic             take_rte_s;

    pc_req_arbiter u_arb (
        .step_req   (step_req),
        .br_req     (br_req),
        .br_taken   (br_taken),
        .j_req      (j_req),
        .jr_req     (jr_req),
        .rte_req    (rte_req),
        .exc_opcode (exc_opcode),
        .exc_ovf    (exc_ovf),
        .exc_div0   (exc_div0),
        .sel        (arb_sel_s),
        .write      (arb_write_s),
        .is_exc     (arb_is_exc_s),
        .cause      (arb_cause_s)
    );

    // Requests are only honoured in IDLE; everything is ignored while busy
    assign take_exc_s = (state_r == ST_IDLE) && arb_is_exc_s;
    assign take_rte_s = (state_r == ST_IDLE) && arb_write_s && (arb_sel_s == PCSEL_EPCOUT);

    // Map the winning cause to its vector address
    always_comb begin
        vec_sel_s = 8'd0;
        case (arb_cause_s)
            CAUSE_OPCODE: vec_sel_s = VEC_OPCODE;
            CAUSE_OVF:    vec_sel_s = VEC_OVF;
            CAUSE_DIV0:   vec_sel_s = VEC_DIV0;
            default:      vec_sel_s = 8'd0;
        endcase
    end

    // Next-state and PC mux / write decode; select holds when nothing is granted
    always_comb begin
        state_nxt_s = state_r;
        sel_s       = last_sel_r;
        pc_write_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arb_is_exc_s) begin
                    state_nxt_s = ST_EXC_SAVE;
                end else if (arb_write_s) begin
                    sel_s      = arb_sel_s;
                    pc_write_s = 1'b1;
                end else begin
                    sel_s      = last_sel_r;
                    pc_write_s = 1'b0;
                end
            end
            ST_EXC_SAVE: begin
                state_nxt_s = ST_EXC_RD;
            end
            ST_EXC_RD: begin
                if (cnt_r == '0) begin
                    state_nxt_s = ST_EXC_LOAD;
                end else begin
                    state_nxt_s = ST_EXC_RD;
                end
            end
            ST_EXC_LOAD: begin
                sel_s       = PCSEL_MEM;
                pc_write_s  = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register, vector-read latency counter and last driven PC select
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            last_sel_r <= PCSEL_ULARESULT;
        end else begin
            state_r    <= state_nxt_s;
            last_sel_r <= sel_s;
            if (state_r == ST_EXC_SAVE) begin
                cnt_r <= CNT_INIT;
            end else if ((state_r == ST_EXC_RD) && (cnt_r != '0)) begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Cause and vector latched at exception entry; sticky cause cleared by rte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cause_r <= CAUSE_NONE;
            vec_r   <= 8'd0;
        end else if (take_exc_s) begin
            cause_r <= arb_cause_s;
            vec_r   <= vec_sel_s;
`ifdef EXC_CAUSE_STICKY_EN
        end else if (take_rte_s) begin
            cause_r <= CAUSE_NONE;
            vec_r   <= vec_r;
`endif
        end else begin
            cause_r <= cause_r;
            vec_r   <= vec_r;
        end
    end

    assign pc_mux_sel = sel_s;
    assign pc_write   = pc_write_s;
    assign epc_write  = (state_r == ST_EXC_SAVE);
    assign mem_rd     = (state_r == ST_EXC_RD);
    assign busy       = (state_r != ST_IDLE);
    assign vec_addr   = vec_r;
`ifdef EXC_CAUSE_STICKY_EN
    assign exc_cause  = cause_r;
    logic unused_rte_s;
    assign unused_rte_s = 1'b0;
`else
    assign exc_cause  = busy ? cause_r : CAUSE_NONE;
    logic unused_rte_s;
    assign unused_rte_s = take_rte_s;
`endif

endmodule
